mem_req_arbiter: RTL

Two-master request arbiter that sits directly upstream of the memory interface block and feeds its valid/ready request port. It merges requests from master 0 (load/store) and master 1 (fetch) with round-robin priority. It tracks outstanding reads in an in-order ID FIFO so each downstream read response is routed back to the master that issued it.

---
 rtl/mem_pkg.sv | 19 +
 rtl/id_fifo.sv | 55 +++++
 rtl/mem_req_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the two-master memory request arbiter: master IDs and the
// request record carried from a master to the memory interface.
package mem_pkg;

  localparam int REQ_DATA_W = 8;
  localparam int REQ_ADDR_W = 4;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of master IDs for outstanding reads; head is visible
// combinationally so a response can be routed in the cycle it arrives.
module id_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  master_id_t push_id,
  input  logic       pop,
  output master_id_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  master_id_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_id;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter merging load/store (m0) and fetch (m1) requests onto one
// memory request port, routing in-order read responses back by issuing master.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_W    = REQ_DATA_W,
  parameter int ADDR_W    = REQ_ADDR_W,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_valid,
  input  logic              m0_req_write,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_req_ready,
  output logic              m0_resp_valid,
  output logic [DATA_W-1:0] m0_resp_rdata,
  input  logic              m1_req_valid,
  input  logic              m1_req_write,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_req_ready,
  output logic              m1_resp_valid,
  output logic [DATA_W-1:0] m1_resp_rdata,
  output logic              mem_req_valid,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              resp_err
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  master_id_t grant, head_id;
  master_id_t last_grant_q, last_grant_d;
  master_id_t lock_id_q, lock_id_d;
  logic       lock_q, lock_d;
  logic       resp_err_q, resp_err_d;
  logic       fifo_full, fifo_empty;
  logic       elig0, elig1, sel_valid, xfer, push, pop;
  req_t       req0, req1, sel_req;

  assign req0  = '{write: m0_req_write, addr: m0_req_addr, wdata: m0_req_wdata};
  assign req1  = '{write: m1_req_write, addr: m1_req_addr, wdata: m1_req_wdata};
  assign elig0 = m0_req_valid && (m0_req_write || !fifo_full);
  assign elig1 = m1_req_valid && (m1_req_write || !fifo_full);

  // Default favours the master that did not win last; lock pins a stalled grant.
  always_comb begin
    grant = (last_grant_q == M0) ? M1 : M0;
    if (lock_q)              grant = lock_id_q;
    else if (elig0 && !elig1) grant = M0;
    else if (elig1 && !elig0) grant = M1;
  end

  assign sel_req   = (grant == M0) ? req0 : req1;
  assign sel_valid = (grant == M0) ? elig0 : elig1;
  assign xfer      = sel_valid && mem_req_ready;
  assign push      = xfer && !sel_req.write;
  assign pop       = mem_resp_valid && !fifo_empty;

  always_comb begin
    last_grant_d = last_grant_q;
    lock_id_d    = lock_id_q;
    lock_d       = lock_q;
    resp_err_d   = resp_err_q || (mem_resp_valid && fifo_empty);
    if (xfer) begin
      last_grant_d = grant;
      lock_d       = 1'b0;
    end else if (sel_valid) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= M1;
      lock_id_q    <= M0;
      lock_q       <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_id_q    <= lock_id_d;
      lock_q       <= lock_d;
      resp_err_q   <= resp_err_d;
    end
  end

  id_fifo #(.DEPTH(MAX_OUTST)) u_id_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .push_id(grant),
    .pop    (pop),
    .head   (head_id),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Outputs are forced low while reset is held, even with live inputs.
  assign mem_req_valid = rst_n && sel_valid;
  assign mem_req_write = rst_n && sel_req.write;
  assign mem_req_addr  = rst_n ? sel_req.addr  : '0;
  assign mem_req_wdata = rst_n ? sel_req.wdata : '0;
  assign m0_req_ready  = rst_n && xfer && (grant == M0);
  assign m1_req_ready  = rst_n && xfer && (grant == M1);
  assign m0_resp_valid = rst_n && pop && (head_id == M0);
  assign m1_resp_valid = rst_n && pop && (head_id == M1);
  assign m0_resp_rdata = rst_n ? mem_resp_rdata : '0;
  assign m1_resp_rdata = rst_n ? mem_resp_rdata : '0;
  assign resp_err      = resp_err_q;

endmodule
